matmul_sequencer: RTL
=====================

# matmul_sequencer

Control and operand-skew block for the DIM×DIM systolic array of multiply-accumulate processing elements. It clears the accumulators and accepts DIM operand beats through a valid/ready handshake. It skews each beat onto the array's west (A) and north (B) edges, flushes the pipeline, then reports completion and aggregated overflow. It sits between the operand source (buffer or host streamer) and the PE array.

## Interface
- DATA_WIDTH, 32, signed operand width; matches the PE operand width
- DIM, 4, array dimension and inner-product length K (≥2)
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- start_i  in  1  start request; sampled only in IDLE
- busy_o  out  1  high from CLEAR through DONE
- done_o  out  1  single-cycle completion pulse
- in_valid_i  in  1  operand beat valid
- in_ready_o  out  1  operand beat ready; high only in LOAD
- a_col_i  in  DIM*DATA_WIDTH  column k of A; slice i = A[i][k]
- b_row_i  in  DIM*DATA_WIDTH  row k of B; slice j = B[k][j]
- pe_a_o  out  DIM*DATA_WIDTH  west-edge operands; slice i drives row i
- pe_b_o  out  DIM*DATA_WIDTH  north-edge operands; slice j drives column j
- pe_clear_o  out  1  synchronous accumulator clear to the array
- ovf_i  in  DIM*DIM  per-PE overflow flags, row-major
- overflow_o  out  1  sticky job overflow; valid from done_o until next start

## Operation
- States:
  - IDLE: start_i=1 → CLEAR.
  - CLEAR: 1 cycle, pe_clear_o=1 → LOAD.
  - LOAD: in_ready_o=1. Beat accepted on valid&ready. Beat counter (0..DIM-1) increments per acceptance. After beat DIM-1 → FLUSH.
  - FLUSH: 2*DIM+1 cycles, counted by flush counter → DONE.
  - DONE: 1 cycle, done_o=1, overflow_o captured → IDLE.
- Skew: slice i of an accepted a_col_i passes through i+1 registers to pe_a_o slice i. B is skewed the same way by column index j. Skew registers shift every cycle in all states.
- Bubbles: any cycle without an accepted beat injects 0 at the skew inputs. Stalls therefore keep A[i][k]/B[k][j] alignment at PE(i,j) and add 0 to accumulators.
- Overflow: in DONE, overflow_o ← OR-reduce(ovf_i). It is cleared to 0 on entry to CLEAR.
- start_i outside IDLE is ignored. in_valid_i outside LOAD is ignored (no acceptance).
- Arithmetic: none in this block. Operands are passed unmodified as signed DATA_WIDTH values.

## Timing
- Reset values: busy_o, done_o, in_ready_o, pe_clear_o, overflow_o = 0; pe_a_o, pe_b_o, all skew registers = 0; state IDLE; counters 0.
- Edge 0 samples start_i. CLEAR is in the cycle after edge 0. LOAD begins after edge 1.
- With no stalls:
  - beats are accepted at edges 2..DIM+1;
  - the last product lands in PE(DIM-1,DIM-1) at edge 3*DIM+1;
  - done_o is high in the cycle after edge 3*DIM+2 (DIM=4: 14).
- Each stall cycle in LOAD delays done_o by exactly one cycle.
- Reset mid-operation: immediate return to reset values. No done_o pulse. The in-flight job is discarded.
- A new start_i in the cycle done_o is high is not sampled; the earliest accepted start is the following IDLE cycle.

## Configuration
- MATMUL_SEQ_OVF_EN defined: the overflow aggregation and capture described above is compiled in.
- Not defined: ovf_i is ignored and overflow_o is constant 0. All other behaviour and timing are identical.

## Structure
- Shared package `matmul_pkg` holds:
  - state enum (IDLE, CLEAR, LOAD, FLUSH, DONE);
  - default DATA_WIDTH/DIM;
  - counter widths via $clog2(DIM) and $clog2(2*DIM+2).
- One sub-module, `skew_line`: parameterised-depth DATA_WIDTH delay line with async reset and a zero-injection input. It is instantiated 2*DIM times, with depth i+1 for row/column i.

## Test plan
- DIM=2. A=[[1,2],[3,4]], B=[[5,6],[7,8]]. Beats ((1,3),(5,6)), ((2,4),(7,8)), no stalls. Required response: array results [[19,22],[43,50]], done_o after edge 8, overflow_o=0.
- Same job with in_valid_i low for 3 cycles between beats → identical results, done_o delayed by exactly 3 cycles.
- Back-to-back jobs, second job with A=I and the same B → results [[5,6],[7,8]]. This proves pe_clear_o cleared the first job's sums.
- rst_ni asserted during FLUSH → all outputs 0 immediately, no done_o. A following job produces correct results.
- MATMUL_SEQ_OVF_EN defined, operands 0x7FFFFFFF×0x7FFFFFFF with DATA_WIDTH=32 accumulated to force a negative sign bit → overflow_o=1 at done_o. The same stimulus without the macro → overflow_o=0.
- start_i pulsed while busy_o=1 → ignored: no second CLEAR, beat count unchanged.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared types and sizing helpers for the systolic-array matmul sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: FSM state encoding, default geometry, and counter-width helpers.
// The helpers are functions because the counter widths depend on the DIM
// parameter of each instance.
package matmul_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_DIM        = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        LOAD  = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } state_e;

    // Beat counter spans 0..DIM-1.
    function automatic int beat_cnt_width(input int dim);
        return (dim > 1) ? $clog2(dim) : 1;
    endfunction

    // Flush counter spans 0..2*DIM.
    function automatic int flush_cnt_width(input int dim);
        return $clog2(2 * dim + 2);
    endfunction

endpackage

// File: rtl/matmul_sequencer_skew_line.sv
// Fixed-depth operand delay line feeding one row/column edge of the PE array.
// Latency: DEPTH cycles from dat_i to dat_o.
// Backpressure: none; the line shifts every cycle and never stalls.
//
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset (all stages to 0)
//   inject_zero_i   when high, a 0 enters the line instead of dat_i
//   dat_i           operand entering the line
//   dat_o           operand leaving the line after DEPTH cycles
module skew_line #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  inject_zero_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    output logic [DATA_WIDTH-1:0] dat_o
);

    logic [DEPTH-1:0][DATA_WIDTH-1:0] stage_q;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] stage_d;

    always_comb begin
        // A bubble must enter as 0 so it contributes nothing to the
        // accumulator it eventually reaches.
        stage_d[0] = inject_zero_i ? '0 : dat_i;
        for (int s = 1; s < DEPTH; s++) begin
            stage_d[s] = stage_q[s-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign dat_o = stage_q[DEPTH-1];

endmodule

// File: rtl/matmul_sequencer.sv
// Sequencer and operand skew for a DIM x DIM output-stationary systolic array.
// Latency: start sampled at edge 0, done_o in the cycle after edge 3*DIM+2 plus one per LOAD stall.
// Backpressure: in_ready_o is high only in LOAD; the source may stall freely, stalls inject zero bubbles.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   start_i                job start, sampled only in IDLE
//   busy_o, done_o         job in progress (CLEAR..DONE) / one-cycle completion pulse
//   in_valid_i, in_ready_o operand beat handshake
//   a_col_i, b_row_i       beat k: slice i = A[i][k], slice j = B[k][j]
//   pe_a_o, pe_b_o         skewed west-edge / north-edge operands to the array
//   pe_clear_o             accumulator clear to the array
//   ovf_i                  per-PE overflow flags, row-major
//   overflow_o             job overflow, valid from done_o until the next start
//
// Build option: MATMUL_SEQ_OVF_EN compiles in overflow aggregation; without it
// ovf_i is ignored and overflow_o is tied to 0.
module matmul_sequencer
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DIM        = DEFAULT_DIM
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      start_i,
    output logic                      busy_o,
    output logic                      done_o,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [DIM*DATA_WIDTH-1:0] a_col_i,
    input  logic [DIM*DATA_WIDTH-1:0] b_row_i,
    output logic [DIM*DATA_WIDTH-1:0] pe_a_o,
    output logic [DIM*DATA_WIDTH-1:0] pe_b_o,
    output logic                      pe_clear_o,
    input  logic [DIM*DIM-1:0]        ovf_i,
    output logic                      overflow_o
);

    localparam int BEAT_W  = beat_cnt_width(DIM);
    localparam int FLUSH_W = flush_cnt_width(DIM);

    localparam logic [BEAT_W-1:0]  BEAT_LAST  = BEAT_W'(DIM - 1);
    // Operands of the last beat need DIM cycles of skew plus DIM-1 hops across
    // the array plus the PE operand register and MAC; 2*DIM+1 flush cycles
    // leave every product in its accumulator one edge before DONE.
    localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(2 * DIM);

    state_e               state_q,     state_d;
    logic [BEAT_W-1:0]    beat_cnt_q,  beat_cnt_d;
    logic [FLUSH_W-1:0]   flush_cnt_q, flush_cnt_d;

    logic in_fire;

    assign in_fire = in_valid_i & in_ready_o;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            beat_cnt_q  <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and counters
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        flush_cnt_d = flush_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                state_d    = LOAD;
                beat_cnt_d = '0;
            end
            LOAD: begin
                if (in_fire) begin
                    if (beat_cnt_q == BEAT_LAST) begin
                        state_d     = FLUSH;
                        beat_cnt_d  = '0;
                        flush_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            FLUSH: begin
                if (flush_cnt_q == FLUSH_LAST) begin
                    state_d     = DONE;
                    flush_cnt_d = '0;
                end else begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d     = IDLE;
                beat_cnt_d  = '0;
                flush_cnt_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (pure decode of the registered state)
    // ------------------------------------------------------------------
    always_comb begin
        busy_o     = 1'b0;
        done_o     = 1'b0;
        in_ready_o = 1'b0;
        pe_clear_o = 1'b0;
        unique case (state_q)
            IDLE: begin
            end
            CLEAR: begin
                busy_o     = 1'b1;
                pe_clear_o = 1'b1;
            end
            LOAD: begin
                busy_o     = 1'b1;
                in_ready_o = 1'b1;
            end
            FLUSH: begin
                busy_o = 1'b1;
            end
            DONE: begin
                busy_o = 1'b1;
                done_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Overflow aggregation
    // ------------------------------------------------------------------
`ifdef MATMUL_SEQ_OVF_EN
    logic ovf_q, ovf_d;

    // Captured on the edge that enters DONE: the last product has already
    // landed one edge earlier, so the PE flags are final, and the result is
    // registered and stable for the whole done_o cycle and afterwards.
    always_comb begin
        ovf_d = ovf_q;
        if (state_q == IDLE && start_i) begin
            ovf_d = 1'b0;
        end else if (state_q == FLUSH && state_d == DONE) begin
            ovf_d = |ovf_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow_o = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ^ovf_i;
    assign overflow_o = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Operand skew: row/column i is delayed by i+1 cycles so that A[i][k]
    // and B[k][j] meet at PE(i,j) on the same cycle.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < DIM; i++) begin : g_skew
        skew_line #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (i + 1)
        ) u_skew_a (
            .clk_i         (clk_i),
            .rst_ni        (rst_ni),
            .inject_zero_i (~in_fire),
            .dat_i         (a_col_i[i*DATA_WIDTH +: DATA_WIDTH]),
            .dat_o         (pe_a_o[i*DATA_WIDTH +: DATA_WIDTH])
        );

        skew_line #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (i + 1)
        ) u_skew_b (
            .clk_i         (clk_i),
            .rst_ni        (rst_ni),
            .inject_zero_i (~in_fire),
            .dat_i         (b_row_i[i*DATA_WIDTH +: DATA_WIDTH]),
            .dat_o         (pe_b_o[i*DATA_WIDTH +: DATA_WIDTH])
        );
    end

endmodule
